// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: song ROM entry layout and FSM state encoding.
package song_pkg;

    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int NUM_W   = 2;
    localparam int META_W  = 3;
    localparam int ENTRY_W = 4 * NOTE_W + DUR_W + NUM_W + META_W;

    // Field order matches the ROM word, MSB first: note1 at [34:29] ... metadata at [2:0].
    typedef struct packed {
        logic [NOTE_W-1:0] note1;
        logic [NOTE_W-1:0] note2;
        logic [NOTE_W-1:0] note3;
        logic [NOTE_W-1:0] note4;
        logic [DUR_W-1:0]  duration;
        logic [NUM_W-1:0]  num_notes;
        logic [META_W-1:0] metadata;
    } entry_t;

    localparam logic [DUR_W-1:0] END_DURATION = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_end(input entry_t e);
        return e.duration == END_DURATION;
    endfunction

endpackage

// File: rtl/song_if.sv
// Note-load handshake between the song sequencer (master) and notes_player (slave).
interface song_if;
    import song_pkg::*;

    // Handshake: load_new_note is a one-cycle strobe marking the note fields valid; the fields
    // then stay stable until notes_player raises done_with_note, which the sequencer accepts
    // only while it is waiting and playing.
    logic [NOTE_W-1:0] note1;
    logic [NOTE_W-1:0] note2;
    logic [NOTE_W-1:0] note3;
    logic [NOTE_W-1:0] note4;
    logic [DUR_W-1:0]  duration;
    logic [NUM_W-1:0]  num_notes;
    logic [META_W-1:0] metadata;
    logic              load_new_note;
    logic              done_with_note;
    logic              play_enable;

    modport master (
        output note1, note2, note3, note4, duration, num_notes, metadata,
        output load_new_note, play_enable,
        input  done_with_note
    );

    modport slave (
        input  note1, note2, note3, note4, duration, num_notes, metadata,
        input  load_new_note, play_enable,
        output done_with_note
    );

endinterface

// File: rtl/song_sequencer.sv
// Walks the song ROM one chord at a time and hands each entry to notes_player,
// handling play/pause, song select, restart and end-of-song.
module song_sequencer
    import song_pkg::*;
#(
    parameter int IDX_W   = 7,
    parameter int SONG_W  = 2,
    parameter int ROM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song,
    input  logic                    restart,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [ENTRY_W-1:0]      rom_data,
    song_if.master                  nif,
    output logic                    song_done,
    output logic                    busy,
    output state_t                  dbg_state
);

    localparam logic [1:0]       LAT_LAST = 2'(ROM_LAT);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [1:0]        lat_cnt, lat_cnt_n;
    logic [SONG_W-1:0] song_r;
    entry_t            fields;
    entry_t            rom_entry;
    logic              latch;
    logic              done_pulse_n;
    logic              abort;

    assign rom_entry = entry_t'(rom_data);

    // Restart or a new song selection drops everything back to IDLE, ahead of pause and done.
    assign abort = (state != ST_IDLE) && (restart || (song != song_r));

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        lat_cnt_n    = lat_cnt;
        latch        = 1'b0;
        done_pulse_n = 1'b0;
        if (abort) begin
            state_n   = ST_IDLE;
            idx_n     = '0;
            lat_cnt_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (play) begin
                        state_n   = ST_FETCH;
                        idx_n     = '0;
                        lat_cnt_n = '0;
                    end
                end
                ST_FETCH: begin
                    if (play) begin
                        if (lat_cnt == LAT_LAST) begin
                            latch     = 1'b1;
                            lat_cnt_n = '0;
                            if (is_end(rom_entry)) begin
                                state_n      = ST_DONE;
                                done_pulse_n = 1'b1;
                            end else begin
                                state_n = ST_LOAD;
                            end
                        end else begin
                            lat_cnt_n = lat_cnt + 2'd1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (play) state_n = ST_WAIT;
                end
                ST_WAIT: begin
                    if (play && nif.done_with_note) begin
                        // The last index ends the song rather than wrapping back to entry 0.
                        if (idx == IDX_LAST) begin
                            state_n      = ST_DONE;
                            done_pulse_n = 1'b1;
                        end else begin
                            state_n   = ST_FETCH;
                            idx_n     = idx + IDX_W'(1);
                            lat_cnt_n = '0;
                        end
                    end
                end
                ST_DONE: begin
                    if (!play) begin
                        state_n = ST_IDLE;
                        idx_n   = '0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            lat_cnt   <= '0;
            song_r    <= '0;
            fields    <= '0;
            song_done <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            lat_cnt   <= lat_cnt_n;
            song_r    <= song;
            song_done <= done_pulse_n;
            if (latch) fields <= rom_entry;
        end
    end

    assign rom_addr = {song_r, idx};

    assign nif.note1     = fields.note1;
    assign nif.note2     = fields.note2;
    assign nif.note3     = fields.note3;
    assign nif.note4     = fields.note4;
    assign nif.duration  = fields.duration;
    assign nif.num_notes = fields.num_notes;
    assign nif.metadata  = fields.metadata;

    // Gating with play defers the strobe while paused in LOAD.
    assign nif.load_new_note = (state == ST_LOAD) && play;
    assign nif.play_enable   = play && ((state == ST_LOAD) || (state == ST_WAIT));
    assign busy              = (state != ST_IDLE) && (state != ST_DONE);
    assign dbg_state         = state;

endmodule
